// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_ctrl: single-outstanding load/store unit behind the EX-stage ALU.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        lsu_stall,
  output logic [31:0] load_result,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_req;
  logic        r_load_valid;
  logic        r_bus_err;
  logic [31:0] r_load_result;

  logic        w_legal;
  logic        w_op;
  logic        w_misal;
  logic        w_accept;
  logic        w_timeout;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;

  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
      default:                                w_legal = 1'b0;
    endcase
  end

  assign w_op      = ex_valid & (mem_read ^ mem_write) & w_legal;
  assign w_misal   = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign w_accept  = w_op & ~w_misal;
  assign w_timeout = (r_cnt == C_CNT_LAST);

  // Lane replication lets the memory pick any byte lane without a shifter.
  always_comb begin
    w_wdata = store_data;
    w_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        w_wdata = {4{store_data[7:0]}};
        w_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{store_data[15:0]}};
        w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = store_data;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  assign w_shifted = dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_ext = w_shifted;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_ext = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_ext = {16'd0, w_shifted[15:0]};
      default: w_load_ext = w_shifted;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUSY;
      S_BUSY:  if (dmem_ack || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_we          <= 1'b0;
      r_funct3      <= 3'd0;
      r_off         <= 2'd0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_wstrb       <= 4'd0;
      r_req         <= 1'b0;
      r_load_valid  <= 1'b0;
      r_bus_err     <= 1'b0;
      r_load_result <= 32'd0;
    end else begin
      r_state      <= w_next;
      r_load_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req    <= 1'b1;
            r_we     <= mem_write;
            r_funct3 <= funct3;
            r_off    <= addr[1:0];
            r_addr   <= {addr[31:2], 2'b00};
            r_wdata  <= w_wdata;
            r_wstrb  <= mem_write ? w_wstrb : 4'b0000;
            r_cnt    <= 8'd0;
          end
        end
        S_BUSY: begin
          // An ack in the last counted cycle takes priority over the timeout.
          if (dmem_ack) begin
            r_req        <= 1'b0;
            r_load_valid <= ~r_we;
            if (!r_we) r_load_result <= w_load_ext;
          end else if (w_timeout) begin
            r_req        <= 1'b0;
            r_bus_err    <= 1'b1;
            r_load_valid <= ~r_we;
            if (!r_we) r_load_result <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign lsu_stall   = ((r_state == S_IDLE) & w_accept) | (r_state == S_BUSY);
  assign misaligned  = (r_state == S_IDLE) & w_op & w_misal;
  assign dmem_req    = r_req;
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign dmem_wstrb  = r_wstrb;
  assign load_valid  = r_load_valid;
  assign bus_err     = r_bus_err;
  assign load_result = r_load_result;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsu_ctrl: directed bench with a transaction-level reference model.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        lsu_stall, load_valid, misaligned, bus_err, dmem_req, dmem_we;
  logic [31:0] load_result, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
    .lsu_stall(lsu_stall), .load_result(load_result), .load_valid(load_valid),
    .misaligned(misaligned), .bus_err(bus_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz = nbytes(f3);
    if (sz == 1) return {24'd0, sd[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'd0, sd[15:0]} * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int sz = nbytes(f3);
    int m = ((1 << sz) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz = nbytes(f3);
    logic [31:0] v, mask;
    v = rd >> (8 * (a % 4));
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v > (mask >> 1)) v = v - (mask + 32'd1);
    return v;
  endfunction

  logic        m_busy = 1'b0, m_resp = 1'b0, m_to = 1'b0, m_load = 1'b0;
  int          m_n = 0;
  logic [2:0]  m_f3 = 3'd0;
  logic [31:0] m_addr = 32'd0, m_sd = 32'd0, m_lr = 32'd0;

  always @(negedge clk) begin : model_cmp
    logic legal, op, al, idle;
    if (reset) begin
      chk("rst_stall", lsu_stall, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_lv", load_valid, 0);
      chk("rst_be", bus_err, 0);
      chk("rst_lr", load_result, 0);
      m_busy = 0; m_resp = 0; m_to = 0; m_n = 0; m_lr = 0;
    end else begin
      legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
              (funct3 == 3'd4) || (funct3 == 3'd5);
      op    = ex_valid && (mem_read != mem_write) && legal;
      al    = (addr % nbytes(funct3)) == 0;
      idle  = !m_busy && !m_resp;
      chk("stall", lsu_stall, m_busy || (idle && op && al));
      chk("misaligned", misaligned, idle && op && !al);
      chk("dmem_req", dmem_req, m_busy);
      chk("load_valid", load_valid, m_resp && m_load);
      chk("bus_err", bus_err, m_resp && m_to);
      chk("load_result", load_result, m_lr);
      if (m_busy) begin
        chk("dmem_we", dmem_we, !m_load);
        chk("dmem_addr", dmem_addr, m_addr & ~32'h3);
        chk("dmem_wdata", dmem_wdata, m_load ? dmem_wdata : model_wdata(m_f3, m_sd));
        chk("dmem_wstrb", dmem_wstrb, m_load ? 4'h0 : model_wstrb(m_f3, m_addr));
      end
      if (m_resp) begin
        m_resp = 0;
      end else if (m_busy) begin
        if (dmem_ack) begin
          m_busy = 0; m_resp = 1; m_to = 0;
          if (m_load) m_lr = model_load(m_f3, m_addr, dmem_rdata);
        end else if (m_n == TO - 1) begin
          m_busy = 0; m_resp = 1; m_to = 1;
          if (m_load) m_lr = 32'd0;
        end else begin
          m_n++;
        end
      end else if (op && al) begin
        m_busy = 1; m_n = 0; m_load = mem_read;
        m_f3 = funct3; m_addr = addr; m_sd = store_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called 1 time unit after a rising edge; returns in the IDLE cycle after RESP.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input int ack_k,
                       input logic [31:0] rdata, output int reqc, output logic st0,
                       output logic [31:0] q_addr, output logic [31:0] q_wdata,
                       output logic [3:0] q_wstrb, output logic q_we, output logic stable,
                       output logic lv, output logic be, output logic [31:0] lr);
    logic seen;
    ex_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    #2 st0 = lsu_stall;
    @(posedge clk); #1;
    ex_valid = 0; mem_read = 0; mem_write = 0;
    reqc = 0; stable = 1; seen = 0; lv = 0; be = 0; lr = 32'hx;
    q_addr = 0; q_wdata = 0; q_wstrb = 0; q_we = 0;
    for (int i = 1; i <= TO + 3 && !seen; i++) begin
      if (i == ack_k) begin dmem_ack = 1; dmem_rdata = rdata; end
      #2;
      if (dmem_req) begin
        reqc++;
        if (reqc == 1) begin
          q_addr = dmem_addr; q_wdata = dmem_wdata; q_wstrb = dmem_wstrb; q_we = dmem_we;
        end else if (q_addr !== dmem_addr || q_wdata !== dmem_wdata ||
                     q_wstrb !== dmem_wstrb || q_we !== dmem_we) begin
          stable = 0;
        end
      end else begin
        seen = 1; lv = load_valid; be = bus_err; lr = load_result;
      end
      @(posedge clk); #1;
      dmem_ack = 0;
    end
  endtask

  task automatic one_cycle(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, output logic mis, output logic st,
                           output logic rq);
    ex_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
    #2 mis = misaligned; st = lsu_stall; rq = dmem_req;
    @(posedge clk); #1;
    ex_valid = 0; mem_read = 0; mem_write = 0;
    #2 rq = rq | dmem_req;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int reqc;
    logic st0, we, stable, lv, be, mis, st, rq;
    logic [31:0] qa, qd, lr;
    logic [3:0] qs;

    @(posedge clk); #1;
    #2;
    chk("lit_rst_req", dmem_req, 0);
    chk("lit_rst_stall", lsu_stall, 0);
    chk("lit_rst_lr", load_result, 0);
    chk("lit_rst_wstrb", dmem_wstrb, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    // LB 0x103, ack in first request cycle
    do_op(1, 0, 3'b000, 32'h103, 0, 1, 32'h80FF_1234, reqc, st0, qa, qd, qs, we, stable, lv, be, lr);
    chk("lb_stall0", st0, 1);
    chk("lb_addr", qa, 32'h100);
    chk("lb_reqc", reqc, 1);
    chk("lb_lv", lv, 1);
    chk("lb_lr", lr, 32'hFFFF_FF80);

    // SH 0x202, ack after 3 cycles
    do_op(0, 1, 3'b001, 32'h202, 32'hDEAD_BEEF, 3, 0, reqc, st0, qa, qd, qs, we, stable, lv, be, lr);
    chk("sh_wdata", qd, 32'hBEEF_BEEF);
    chk("sh_wstrb", qs, 4'b1100);
    chk("sh_we", we, 1);
    chk("sh_reqc", reqc, 3);
    chk("sh_stable", stable, 1);
    chk("sh_lv", lv, 0);
    chk("sh_lr_kept", lr, 32'hFFFF_FF80);

    // LHU then LW back-to-back at 0
    do_op(1, 0, 3'b101, 32'h0, 0, 1, 32'h0000_F00D, reqc, st0, qa, qd, qs, we, stable, lv, be, lr);
    chk("lhu_lr", lr, 32'h0000_F00D);
    do_op(1, 0, 3'b010, 32'h0, 0, 1, 32'h0000_F00D, reqc, st0, qa, qd, qs, we, stable, lv, be, lr);
    chk("lw_b2b_stall0", st0, 1);
    chk("lw_b2b_reqc", reqc, 1);
    chk("lw_lr", lr, 32'h0000_F00D);

    // extra lanes: SB, LBU, LH
    do_op(0, 1, 3'b000, 32'h101, 32'h1234_5678, 2, 0, reqc, st0, qa, qd, qs, we, stable, lv, be, lr);
    chk("sb_wdata", qd, 32'h7878_7878);
    chk("sb_wstrb", qs, 4'b0010);
    do_op(1, 0, 3'b100, 32'h102, 0, 1, 32'h00AB_0000, reqc, st0, qa, qd, qs, we, stable, lv, be, lr);
    chk("lbu_lr", lr, 32'h0000_00AB);
    do_op(1, 0, 3'b001, 32'h2, 0, 2, 32'h8001_0000, reqc, st0, qa, qd, qs, we, stable, lv, be, lr);
    chk("lh_lr", lr, 32'hFFFF_8001);

    // misaligned LW, illegal funct3, read+write together
    one_cycle(1, 0, 3'b010, 32'h6, mis, st, rq);
    chk("mis_flag", mis, 1);
    chk("mis_stall", st, 0);
    chk("mis_req", rq, 0);
    one_cycle(1, 0, 3'b011, 32'h0, mis, st, rq);
    chk("ill_stall", st, 0);
    chk("ill_req", rq, 0);
    one_cycle(1, 1, 3'b010, 32'h0, mis, st, rq);
    chk("rw_stall", st, 0);
    chk("rw_req", rq, 0);

    // timeout, then ack in the last counted cycle
    do_op(1, 0, 3'b010, 32'h10, 0, 0, 0, reqc, st0, qa, qd, qs, we, stable, lv, be, lr);
    chk("to_reqc", reqc, TO);
    chk("to_be", be, 1);
    chk("to_lr", lr, 0);
    do_op(1, 0, 3'b010, 32'h10, 0, TO, 32'h1122_3344, reqc, st0, qa, qd, qs, we, stable, lv, be, lr);
    chk("ack4_reqc", reqc, TO);
    chk("ack4_be", be, 0);
    chk("ack4_lr", lr, 32'h1122_3344);

    // reset in the middle of BUSY
    ex_valid = 1; mem_read = 1; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    ex_valid = 0; mem_read = 0;
    @(posedge clk); #1;
    reset = 1;
    #2;
    chk("rbusy_req", dmem_req, 0);
    chk("rbusy_stall", lsu_stall, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    do_op(1, 0, 3'b010, 32'h44, 0, 1, 32'hCAFE_0001, reqc, st0, qa, qd, qs, we, stable, lv, be, lr);
    chk("post_rst_reqc", reqc, 1);
    chk("post_rst_lr", lr, 32'hCAFE_0001);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
